// File: rtl/spi_master_ctrl.sv
// SPI master: serialises host command words onto SS_n/MOSI at one bit per clk
// and captures the MISO reply byte for read-data commands.
module spi_master_ctrl #(
    parameter int FRAME_BITS = 10,
    parameter int RD_BITS    = 8,
    parameter int MISO_DLY   = 2,
    parameter int GAP        = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [FRAME_BITS-1:0] cmd_data,
    output logic                  rsp_valid,
    output logic [RD_BITS-1:0]    rsp_data,
    output logic                  busy,
    output logic                  SS_n,
    output logic                  MOSI,
    input  logic                  MISO,
    output logic [2:0]            dbg_state
);
    localparam int CNT_W = $clog2(FRAME_BITS + RD_BITS + 17);
    localparam logic [CNT_W-1:0] FRAME_END = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(MISO_DLY - 1);
    localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(RD_BITS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SEND    = 3'd1,
        S_WAIT_RD = 3'd2,
        S_RECV    = 3'd3,
        S_GAP     = 3'd4
    } state_t;

    state_t                state, state_next;
    logic [CNT_W-1:0]      cnt, cnt_next;
    logic [FRAME_BITS-1:0] shreg, shreg_next;
    logic [1:0]            op, op_next;
    logic [RD_BITS-1:0]    rx, rx_next;
    logic [RD_BITS-1:0]    rsp_data_next;
    logic                  rsp_valid_next;
    logic                  ss_next;
    logic                  mosi_next;

    // Handshake: a command transfers on a rising edge where cmd_valid and
    // cmd_ready are both high; cmd_ready is high only in IDLE, so anything
    // presented while busy is simply not taken.
    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        shreg_next     = shreg;
        op_next        = op;
        rx_next        = rx;
        rsp_data_next  = rsp_data;
        rsp_valid_next = 1'b0;
        ss_next        = SS_n;
        mosi_next      = MOSI;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    shreg_next = {cmd_data[FRAME_BITS-2:0], 1'b0};
                    op_next    = cmd_data[FRAME_BITS-1 -: 2];
                    ss_next    = 1'b0;
                    mosi_next  = cmd_data[FRAME_BITS-1];
                    cnt_next   = CNT_ONE;
                    state_next = S_SEND;
                end
            end
            S_SEND: begin
                if (cnt != FRAME_END) begin
                    mosi_next  = shreg[FRAME_BITS-1];
                    shreg_next = shreg << 1;
                    cnt_next   = cnt + CNT_ONE;
                end else begin
                    mosi_next = 1'b0;
                    cnt_next  = '0;
                    if (op == 2'b11) begin
                        state_next = (MISO_DLY == 0) ? S_RECV : S_WAIT_RD;
                    end else begin
                        ss_next    = 1'b1;
                        state_next = (GAP == 0) ? S_IDLE : S_GAP;
                    end
                end
            end
            S_WAIT_RD: begin
                if (cnt == DLY_LAST) begin
                    cnt_next   = '0;
                    state_next = S_RECV;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            S_RECV: begin
                rx_next = {rx[RD_BITS-2:0], MISO};
                if (cnt == RD_LAST) begin
                    rsp_data_next  = {rx[RD_BITS-2:0], MISO};
                    rsp_valid_next = 1'b1;
                    ss_next        = 1'b1;
                    cnt_next       = '0;
                    state_next     = (GAP == 0) ? S_IDLE : S_GAP;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            S_GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_next   = '0;
                    state_next = S_IDLE;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
                ss_next    = 1'b1;
                mosi_next  = 1'b0;
            end
        endcase
    end

    // Reset releases the slave at once and drops any partial reply.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            shreg     <= '0;
            op        <= '0;
            rx        <= '0;
            rsp_data  <= '0;
            rsp_valid <= 1'b0;
            SS_n      <= 1'b1;
            MOSI      <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            shreg     <= shreg_next;
            op        <= op_next;
            rx        <= rx_next;
            rsp_data  <= rsp_data_next;
            rsp_valid <= rsp_valid_next;
            SS_n      <= ss_next;
            MOSI      <= mosi_next;
        end
    end

endmodule
